ifu_fetch: RTL and testbench

- Instruction fetch unit for the NPC core: holds the architectural PC and issues one 32-bit instruction read at a time on an AXI4-Lite read channel.
- Presents each {pc, inst} pair to the decode stage with a valid/ready handshake.
- Accepts PC redirects from the branch unit and the CSR unit (ecall/mret) and discards any fetch that a redirect makes stale.

---
 rtl/ifu_fetch_pkg.sv | 31 +++
 rtl/ifu_pc_reg.sv | 45 ++++
 rtl/ifu_fetch.sv | 151 +++++++++++++++
 tb/tb_ifu_fetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// ============================================================================
// Module   : ifu_fetch_pkg
// Purpose  : Shared types and constants for the NPC instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_fetch_pkg;

   localparam int NPC_ADDR_BUS = 32;
   localparam int NPC_DATA_BUS = 32;

   // Reset is active-low: RESET_ENABLE is the asserted level.
   localparam logic RESET_ENABLE  = 1'b0;
   localparam logic RESET_DISABLE = 1'b1;

   localparam int IFU_STATE_BUS = 2;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   localparam logic [NPC_ADDR_BUS-1:0] RESET_PC_VALUE = 32'h8000_0000;

   typedef enum logic [IFU_STATE_BUS-1:0] {
      IFU_AR  = 2'd0,
      IFU_R   = 2'd1,
      IFU_OUT = 2'd2
   } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/ifu_pc_reg.sv
// ============================================================================
// Module   : ifu_pc_reg
// Purpose  : Architectural PC register with +4 increment and redirect mux.
//            A redirect always takes priority over a sequential advance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_pc_reg
   import ifu_fetch_pkg::*;
#(
   parameter int                ADDR_W   = NPC_ADDR_BUS,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_VALUE
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              advance,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_next
);

   // Next PC: redirect target, sequential successor, or hold.
   always_comb begin
      pc_next = pc;
      if (redirect_valid) begin
         pc_next = redirect_pc;
      end else if (advance) begin
         pc_next = pc + ADDR_W'(4);
      end
   end

   // PC register; the increment wraps naturally at the top of the address space.
   always_ff @(posedge clock) begin
      if (reset == RESET_ENABLE) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Instruction fetch unit. Issues one AXI4-Lite read at a time,
//            presents {pc, inst} to decode, and discards stale fetches after
//            a PC redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int                ADDR_W   = NPC_ADDR_BUS,
   parameter int                DATA_W   = NPC_DATA_BUS,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_VALUE
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic [ADDR_W-1:0] araddr_o,
   output logic              arvalid_o,
   input  logic              arready_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [1:0]        rresp_i,
   input  logic              rvalid_i,
   output logic              rready_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [DATA_W-1:0] inst_o,
   output logic              fault_o
);

   ifu_state_e        state;
   ifu_state_e        state_next;
   logic              flush;
   logic              flush_next;
   logic              capture;
   logic              advance;
   logic              load_addr;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] araddr;
   logic [ADDR_W-1:0] pc_out;
   logic [DATA_W-1:0] inst;
   logic              fault;

   ifu_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clock          (clock),
      .reset          (reset),
      .advance        (advance),
      .redirect_valid (redirect_valid_i),
      .redirect_pc    (redirect_pc_i),
      .pc             (pc),
      .pc_next        (pc_next)
   );

   // Next-state, flush tracking and handshake outputs.
   always_comb begin
      state_next = state;
      flush_next = flush;
      capture    = 1'b0;
      advance    = 1'b0;
      // arvalid is suppressed while reset is held so nothing is requested
      // before the core is released.
      arvalid_o  = (state == IFU_AR) && (reset == RESET_DISABLE);
      rready_o   = (state == IFU_R);
      valid_o    = (state == IFU_OUT);
      case (state)
         IFU_AR: begin
            // The address stays on the bus; a redirect only marks the
            // eventual response as stale.
            flush_next = flush | redirect_valid_i;
            if (arready_i) begin
               state_next = IFU_R;
            end
         end
         IFU_R: begin
            if (rvalid_i) begin
               if (flush || redirect_valid_i) begin
                  flush_next = 1'b0;
                  state_next = IFU_AR;
               end else begin
                  capture    = 1'b1;
                  state_next = IFU_OUT;
               end
            end else if (redirect_valid_i) begin
               flush_next = 1'b1;
            end
         end
         IFU_OUT: begin
            // A redirect cancels the pending instruction even if decode is ready.
            if (redirect_valid_i) begin
               state_next = IFU_AR;
            end else if (ready_i) begin
               advance    = 1'b1;
               state_next = IFU_AR;
            end
         end
         default: begin
            state_next = IFU_AR;
         end
      endcase
      load_addr = (state != IFU_AR) && (state_next == IFU_AR);
   end

   // State and flush registers.
   always_ff @(posedge clock) begin
      if (reset == RESET_ENABLE) begin
         state <= IFU_AR;
         flush <= 1'b0;
      end else begin
         state <= state_next;
         flush <= flush_next;
      end
   end

   // Read address is loaded only on entry to AR so it stays stable until accepted.
   always_ff @(posedge clock) begin
      if (reset == RESET_ENABLE) begin
         araddr <= RESET_PC;
      end else if (load_addr) begin
         araddr <= pc_next;
      end
   end

   // Decode-side payload, held while decode stalls.
   always_ff @(posedge clock) begin
      if (reset == RESET_ENABLE) begin
         pc_out <= RESET_PC;
         inst   <= '0;
         fault  <= 1'b0;
      end else if (capture) begin
         pc_out <= pc;
         inst   <= rdata_i;
         fault  <= (rresp_i != AXI_RESP_OKAY);
      end
   end

   assign araddr_o = araddr;
   assign pc_o     = pc_out;
   assign inst_o   = inst;
   assign fault_o  = fault;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module   : tb_ifu_fetch
// Purpose  : Self-checking bench for ifu_fetch with an AXI4-Lite memory
//            responder and a scoreboard of expected decode handshakes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] araddr_o;
   logic        arvalid_o;
   logic        arready_i;
   logic [31:0] rdata_i  = '0;
   logic [1:0]  rresp_i  = '0;
   logic        rvalid_i = 1'b0;
   logic        rready_o;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        fault_o;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] err_addr;

   ifu_fetch u_dut (
      .clock            (clock),
      .reset            (reset),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .araddr_o         (araddr_o),
      .arvalid_o        (arvalid_o),
      .arready_i        (arready_i),
      .rdata_i          (rdata_i),
      .rresp_i          (rresp_i),
      .rvalid_i         (rvalid_i),
      .rready_o         (rready_o),
      .valid_o          (valid_o),
      .ready_i          (ready_i),
      .pc_o             (pc_o),
      .inst_o           (inst_o),
      .fault_o          (fault_o)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0010_0093;
      return (a ^ 32'h1357_9BDF) | 32'h3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_fetch(input logic [31:0] a, input logic f);
      exp_t e;
      e.pc    = a;
      e.inst  = mem_word(a);
      e.fault = f;
      sb.push_back(e);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_arvalid"}, {31'b0, arvalid_o}, 32'd0);
      chk({tag, "_rready"},  {31'b0, rready_o},  32'd0);
      chk({tag, "_valid"},   {31'b0, valid_o},   32'd0);
      chk({tag, "_fault"},   {31'b0, fault_o},   32'd0);
      chk({tag, "_inst"},    inst_o,             32'h0);
      chk({tag, "_pc"},      pc_o,               32'h8000_0000);
      chk({tag, "_araddr"},  araddr_o,           32'h8000_0000);
   endtask

   task automatic wait_ar(input string tag, input logic [31:0] addr);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (arvalid_o) seen = 1'b1;
      end
      checks++;
      assert (seen) else begin
         failures++;
         $error("FAIL %s_timeout observed=no_arvalid expected=arvalid", tag);
      end
      if (seen) chk(tag, araddr_o, addr);
   endtask

   task automatic wait_valid(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (valid_o) seen = 1'b1;
      end
      checks++;
      assert (seen) else begin
         failures++;
         $error("FAIL %s_timeout observed=no_valid expected=valid", tag);
      end
   endtask

   // Zero-wait AXI4-Lite read responder; data arrives the cycle after the AR handshake.
   always @(posedge clock) begin
      if (!reset) begin
         rvalid_i <= 1'b0;
         rdata_i  <= '0;
         rresp_i  <= 2'b00;
      end else begin
         if (rvalid_i && rready_o) rvalid_i <= 1'b0;
         if (arvalid_o && arready_i) begin
            rvalid_i <= 1'b1;
            rdata_i  <= mem_word(araddr_o);
            rresp_i  <= (araddr_o == err_addr) ? 2'b10 : 2'b00;
         end
      end
   end

   // Scoreboard: every decode handshake must match the oldest expected fetch.
   always @(negedge clock) begin
      exp_t e;
      if (reset && valid_o && ready_i && !redirect_valid_i) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL accept_unexpected observed=%h expected=none", pc_o);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("acc_pc", pc_o, e.pc);
            chk("acc_inst", inst_o, e.inst);
            chk("acc_fault", {31'b0, fault_o}, {31'b0, e.fault});
         end
      end
   end

   initial begin
      reset            = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = '0;
      arready_i        = 1'b1;
      ready_i          = 1'b1;
      err_addr         = 32'h8000_0008;
      tick(); tick(); tick();
      chk_reset("rst0");

      // First fetch after reset release, zero-wait memory.
      expect_fetch(32'h8000_0000, 1'b0);
      reset = 1'b1;
      #1;
      chk("t1_arvalid", {31'b0, arvalid_o}, 32'd1);
      chk("t1_araddr", araddr_o, 32'h8000_0000);
      tick();
      chk("t1_rready", {31'b0, rready_o}, 32'd1);
      tick();
      chk("t1_valid_c3", {31'b0, valid_o}, 32'd1);
      chk("t1_pc", pc_o, 32'h8000_0000);
      chk("t1_inst", inst_o, 32'h0010_0093);
      tick();
      chk("t1_next_arvalid", {31'b0, arvalid_o}, 32'd1);
      chk("t1_next_araddr", araddr_o, 32'h8000_0004);

      // Decode stall holds the payload and blocks new fetches.
      ready_i = 1'b0;
      expect_fetch(32'h8000_0004, 1'b0);
      tick(); tick();
      chk("t2_valid", {31'b0, valid_o}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_hold_pc", pc_o, 32'h8000_0004);
         chk("t2_hold_inst", inst_o, mem_word(32'h8000_0004));
         chk("t2_no_arvalid", {31'b0, arvalid_o}, 32'd0);
      end
      ready_i = 1'b1;
      tick();
      chk("t2_next_araddr", araddr_o, 32'h8000_0008);

      // Error response is still presented, flagged as a fault.
      expect_fetch(32'h8000_0008, 1'b1);
      wait_valid("t5_valid");
      chk("t5_fault", {31'b0, fault_o}, 32'd1);
      chk("t5_pc", pc_o, 32'h8000_0008);
      expect_fetch(32'h8000_000C, 1'b0);
      wait_ar("t5_next_ar", 32'h8000_000C);
      wait_valid("t5_next_valid");
      chk("t5_next_fault", {31'b0, fault_o}, 32'd0);

      // Redirect while the address phase is stalled.
      arready_i = 1'b0;
      err_addr  = 32'h0000_0001;
      tick();
      chk("t3_arvalid", {31'b0, arvalid_o}, 32'd1);
      chk("t3_araddr", araddr_o, 32'h8000_0010);
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0100;
      tick();
      redirect_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t3_hold_araddr", araddr_o, 32'h8000_0010);
         chk("t3_hold_arvalid", {31'b0, arvalid_o}, 32'd1);
         tick();
      end
      arready_i = 1'b1;
      expect_fetch(32'h8000_0100, 1'b0);
      wait_ar("t3_new_ar", 32'h8000_0100);
      wait_valid("t3_valid");
      chk("t3_pc", pc_o, 32'h8000_0100);

      // Redirect in OUT with decode ready: the instruction is not accepted.
      wait_ar("t4_ar", 32'h8000_0104);
      wait_valid("t4_valid");
      chk("t4_pc", pc_o, 32'h8000_0104);
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0040;
      tick();
      redirect_valid_i = 1'b0;
      chk("t4_valid_drop", {31'b0, valid_o}, 32'd0);
      chk("t4_arvalid", {31'b0, arvalid_o}, 32'd1);
      chk("t4_araddr", araddr_o, 32'h8000_0040);
      expect_fetch(32'h8000_0040, 1'b0);
      wait_valid("t4_new_valid");
      chk("t4_new_pc", pc_o, 32'h8000_0040);

      // Reset during R.
      wait_ar("t6_ar", 32'h8000_0044);
      tick();
      chk("t6_rready", {31'b0, rready_o}, 32'd1);
      reset = 1'b0;
      tick();
      chk_reset("rst_in_r");
      reset   = 1'b1;
      ready_i = 1'b0;
      #1;
      chk("t6_rel_arvalid", {31'b0, arvalid_o}, 32'd1);
      chk("t6_rel_araddr", araddr_o, 32'h8000_0000);

      // Reset during OUT.
      wait_valid("t6_valid");
      chk("t6_pc", pc_o, 32'h8000_0000);
      chk("t6_inst", inst_o, 32'h0010_0093);
      reset = 1'b0;
      tick();
      chk_reset("rst_in_out");
      ready_i = 1'b1;
      expect_fetch(32'h8000_0000, 1'b0);
      reset = 1'b1;
      #1;
      chk("t6_rel2_araddr", araddr_o, 32'h8000_0000);
      wait_valid("t6_rel2_valid");

      // Wrap from the top of the address space.
      tick();
      chk("w_ar", araddr_o, 32'h8000_0004);
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'hFFFF_FFFC;
      expect_fetch(32'hFFFF_FFFC, 1'b0);
      tick();
      redirect_valid_i = 1'b0;
      wait_ar("w_top_ar", 32'hFFFF_FFFC);
      wait_valid("w_top_valid");
      chk("w_top_pc", pc_o, 32'hFFFF_FFFC);
      expect_fetch(32'h0000_0000, 1'b0);
      wait_ar("w_wrap_ar", 32'h0000_0000);
      wait_valid("w_wrap_valid");
      tick();
      ready_i = 1'b0;
      tick(); tick();
      chk("sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
